// File: rtl/seq_serializer.sv
// Parallel-to-serial converter with a one-word holding buffer so that
// back-to-back words stream out with no idle bit between them.
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             data,
  output logic             data_valid,
  output logic             data_last,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             data_q, data_valid_q, data_last_q;
  logic             accept;

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) return {v[WIDTH-2:0], 1'b0};
    else           return {1'b0, v[WIDTH-1:1]};
  endfunction

  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) return v[WIDTH-1];
    else           return v[0];
  endfunction

  // Ready depends only on buffer occupancy (and reset), never on in_valid.
  assign in_ready = ~rst & ~hold_full_q;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d  = in_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != LAST) begin
          sreg_d = shift_once(sreg_q);
          cnt_d  = cnt_q + CW'(1);
          if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          sreg_d      = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
        end else if (accept) begin
          sreg_d = in_data;
          cnt_d  = '0;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so bit 0 of a word
  // is already on the line right after its accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      cnt_q        <= '0;
      data_q       <= 1'b0;
      data_valid_q <= 1'b0;
      data_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      cnt_q        <= cnt_d;
      data_q       <= (state_d == SHIFT) ? out_bit(sreg_d) : 1'b0;
      data_valid_q <= (state_d == SHIFT);
      data_last_q  <= (state_d == SHIFT) && (cnt_d == LAST);
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign data_last  = data_last_q;
  assign busy       = (state_q == SHIFT) | hold_full_q;

endmodule
